// File: rtl/kmeans_pkg.sv
// kmeans_pkg: parameters and types shared by the k-means statistics blocks.
//   N_POINTS, K, COORD_W, LABEL_W, ADDR_W : dataset and label geometry
//   CNT_W, SUM_W                          : derived counter / sum widths
//   state_t                               : cluster_stats FSM states
//   cluster_rec_t                         : per-cluster accumulator record
// Optional feature macro: CLUSTER_BBOX_EN adds bounding-box fields.
package kmeans_pkg;

  localparam int N_POINTS = 12;
  localparam int K        = 3;
  localparam int COORD_W  = 8;
  localparam int LABEL_W  = 2;
  localparam int ADDR_W   = 4;

  localparam int CNT_W = $clog2(N_POINTS + 1);
  // A sum of at most N_POINTS coordinates cannot exceed this width.
  localparam int SUM_W = COORD_W + CNT_W;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DRAIN,
    EMIT,
    FIN
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0]   count;
    logic [SUM_W-1:0]   sum_x;
    logic [SUM_W-1:0]   sum_y;
    logic [SUM_W-1:0]   sum_z;
`ifdef CLUSTER_BBOX_EN
    logic [COORD_W-1:0] min_x;
    logic [COORD_W-1:0] min_y;
    logic [COORD_W-1:0] min_z;
    logic [COORD_W-1:0] max_x;
    logic [COORD_W-1:0] max_y;
    logic [COORD_W-1:0] max_z;
`endif
  } cluster_rec_t;

endpackage

// File: rtl/cluster_acc.sv
// cluster_acc: K-entry bank of per-cluster accumulators.
//   clk    : clock, rising edge
//   clr    : clear all entries (count/sums 0, min all-ones, max 0)
//   upd    : add point (x, y, z) to entry 'label' (caller guarantees label < K)
//   rd_idx : entry selected onto rd_rec (combinational read)
// Optional feature macro: CLUSTER_BBOX_EN adds min/max tracking.
module cluster_acc
  import kmeans_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               upd,
  input  logic [LABEL_W-1:0] label,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] z,
  input  logic [LABEL_W-1:0] rd_idx,
  output cluster_rec_t       rd_rec
);

  cluster_rec_t bank [K];

  // NOTE: the bank has no reset; it is always cleared by 'clr' before use and
  // its contents only reach the outputs qualified by the owner's valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < K; i++) begin
      if (clr) begin
        bank[i].count <= '0;
        bank[i].sum_x <= '0;
        bank[i].sum_y <= '0;
        bank[i].sum_z <= '0;
`ifdef CLUSTER_BBOX_EN
        bank[i].min_x <= '1;
        bank[i].min_y <= '1;
        bank[i].min_z <= '1;
        bank[i].max_x <= '0;
        bank[i].max_y <= '0;
        bank[i].max_z <= '0;
`endif
      end else if (upd && int'(label) == i) begin
        bank[i].count <= bank[i].count + CNT_W'(1);
        bank[i].sum_x <= bank[i].sum_x + SUM_W'(x);
        bank[i].sum_y <= bank[i].sum_y + SUM_W'(y);
        bank[i].sum_z <= bank[i].sum_z + SUM_W'(z);
`ifdef CLUSTER_BBOX_EN
        if (x < bank[i].min_x) bank[i].min_x <= x;
        if (y < bank[i].min_y) bank[i].min_y <= y;
        if (z < bank[i].min_z) bank[i].min_z <= z;
        if (x > bank[i].max_x) bank[i].max_x <= x;
        if (y > bank[i].max_y) bank[i].max_y <= y;
        if (z > bank[i].max_z) bank[i].max_z <= z;
`endif
      end
    end
  end

  always_comb begin
    rd_rec = '0;
    if (int'(rd_idx) < K) rd_rec = bank[rd_idx];
  end

endmodule

// File: rtl/cluster_stats.sv
// cluster_stats: scans the point memory once after 'start' and emits one
// statistics record per cluster on a valid/ready stream.
//   clk, rst (sync, active-low)   : clock / reset
//   start                         : begin a scan (ignored unless idle)
//   rd_addr / rd_x,y,z / rd_label : point memory port, 1-cycle read latency
//   out_valid / out_ready         : record handshake
//   out_cluster, out_count, out_sum_x/y/z : record fields
//   out_min_x/y/z, out_max_x/y/z  : bounding box (CLUSTER_BBOX_EN only)
//   busy, done, lbl_err           : status; lbl_err is sticky until next start
// Optional feature macro: CLUSTER_BBOX_EN.
module cluster_stats
  import kmeans_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [COORD_W-1:0] rd_x,
  input  logic [COORD_W-1:0] rd_y,
  input  logic [COORD_W-1:0] rd_z,
  input  logic [LABEL_W-1:0] rd_label,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LABEL_W-1:0] out_cluster,
  output logic [CNT_W-1:0]   out_count,
  output logic [SUM_W-1:0]   out_sum_x,
  output logic [SUM_W-1:0]   out_sum_y,
  output logic [SUM_W-1:0]   out_sum_z,
`ifdef CLUSTER_BBOX_EN
  output logic [COORD_W-1:0] out_min_x,
  output logic [COORD_W-1:0] out_min_y,
  output logic [COORD_W-1:0] out_min_z,
  output logic [COORD_W-1:0] out_max_x,
  output logic [COORD_W-1:0] out_max_y,
  output logic [COORD_W-1:0] out_max_z,
`endif
  output logic               busy,
  output logic               done,
  output logic               lbl_err
);

  state_t             state, state_nxt;
  logic [LABEL_W-1:0] emit_idx;
  logic               rd_vld;     // rd_* carries a point requested last cycle
  logic               label_ok;
  logic               acc_clr;
  logic               acc_upd;
  logic               last_addr;
  cluster_rec_t       rec;

  assign label_ok  = int'(rd_label) < K;
  assign acc_upd   = rd_vld && label_ok;
  assign last_addr = rd_addr == ADDR_W'(N_POINTS - 1);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    acc_clr   = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = state != IDLE;
    case (state)
      IDLE:  if (start) begin
               state_nxt = SCAN;
               acc_clr   = 1'b1;
             end
      SCAN:  if (last_addr) state_nxt = DRAIN;
      DRAIN: state_nxt = EMIT;
      EMIT:  begin
               out_valid = 1'b1;
               if (out_ready && emit_idx == LABEL_W'(K - 1)) state_nxt = FIN;
             end
      FIN:   begin
               done      = 1'b1;
               state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      rd_addr  <= '0;
      emit_idx <= '0;
      rd_vld   <= 1'b0;
      lbl_err  <= 1'b0;
    end else begin
      state  <= state_nxt;
      rd_vld <= state == SCAN;
      if (acc_clr) begin
        rd_addr <= '0;
        lbl_err <= 1'b0;
      end else begin
        // Address holds at the last point after SCAN; it is not wrapped.
        if (state == SCAN && !last_addr) rd_addr <= rd_addr + ADDR_W'(1);
        if (rd_vld && !label_ok) lbl_err <= 1'b1;
      end
      if (state == DRAIN)              emit_idx <= '0;
      else if (out_valid && out_ready) emit_idx <= emit_idx + LABEL_W'(1);
    end
  end

  cluster_acc u_acc (
    .clk    (clk),
    .clr    (acc_clr),
    .upd    (acc_upd),
    .label  (rd_label),
    .x      (rd_x),
    .y      (rd_y),
    .z      (rd_z),
    .rd_idx (emit_idx),
    .rd_rec (rec)
  );

  // Record fields read as zero whenever no record is being offered, which also
  // gives the all-zero reset values without resetting the accumulator bank.
  assign out_cluster = out_valid ? emit_idx  : '0;
  assign out_count   = out_valid ? rec.count : '0;
  assign out_sum_x   = out_valid ? rec.sum_x : '0;
  assign out_sum_y   = out_valid ? rec.sum_y : '0;
  assign out_sum_z   = out_valid ? rec.sum_z : '0;
`ifdef CLUSTER_BBOX_EN
  assign out_min_x   = out_valid ? rec.min_x : '0;
  assign out_min_y   = out_valid ? rec.min_y : '0;
  assign out_min_z   = out_valid ? rec.min_z : '0;
  assign out_max_x   = out_valid ? rec.max_x : '0;
  assign out_max_y   = out_valid ? rec.max_y : '0;
  assign out_max_z   = out_valid ? rec.max_z : '0;
`endif

endmodule

// File: tb/tb_cluster_stats.sv
// tb_cluster_stats: self-checking bench for cluster_stats. A behavioural point
// memory feeds the DUT; expected records go into a scoreboard queue when a
// scan is started and are popped on each output handshake.
// Honours CLUSTER_BBOX_EN for the bounding-box ports and fields.
module tb_cluster_stats;
  import kmeans_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               out_ready = 1'b1;
  logic [ADDR_W-1:0]  rd_addr;
  logic [COORD_W-1:0] rd_x = '0, rd_y = '0, rd_z = '0;
  logic [LABEL_W-1:0] rd_label = '0;
  logic               out_valid, busy, done, lbl_err;
  logic [LABEL_W-1:0] out_cluster;
  logic [CNT_W-1:0]   out_count;
  logic [SUM_W-1:0]   out_sum_x, out_sum_y, out_sum_z;
`ifdef CLUSTER_BBOX_EN
  logic [COORD_W-1:0] out_min_x, out_min_y, out_min_z;
  logic [COORD_W-1:0] out_max_x, out_max_y, out_max_z;
`endif

  cluster_stats dut (
    .clk (clk), .rst (rst), .start (start),
    .rd_addr (rd_addr), .rd_x (rd_x), .rd_y (rd_y), .rd_z (rd_z), .rd_label (rd_label),
    .out_valid (out_valid), .out_ready (out_ready), .out_cluster (out_cluster),
    .out_count (out_count), .out_sum_x (out_sum_x), .out_sum_y (out_sum_y), .out_sum_z (out_sum_z),
`ifdef CLUSTER_BBOX_EN
    .out_min_x (out_min_x), .out_min_y (out_min_y), .out_min_z (out_min_z),
    .out_max_x (out_max_x), .out_max_y (out_max_y), .out_max_z (out_max_z),
`endif
    .busy (busy), .done (done), .lbl_err (lbl_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LABEL_W-1:0] cl;
    cluster_rec_t       r;
  } exp_t;

  exp_t exp_q [$];
  int   errors = 0;
  int   checks = 0;

  logic [COORD_W-1:0] mem_x [N_POINTS];
  logic [COORD_W-1:0] mem_y [N_POINTS];
  logic [COORD_W-1:0] mem_z [N_POINTS];
  logic [LABEL_W-1:0] mem_l [N_POINTS];

  // Synchronous read port: data for the address sampled at this edge.
  always @(posedge clk) begin
    if (int'(rd_addr) < N_POINTS) begin
      rd_x <= mem_x[rd_addr]; rd_y <= mem_y[rd_addr];
      rd_z <= mem_z[rd_addr]; rd_label <= mem_l[rd_addr];
    end else begin
      rd_x <= '0; rd_y <= '0; rd_z <= '0; rd_label <= '0;
    end
  end

  function automatic exp_t observe();
    exp_t o;
    o = '0;
    o.cl = out_cluster;
    o.r.count = out_count;
    o.r.sum_x = out_sum_x; o.r.sum_y = out_sum_y; o.r.sum_z = out_sum_z;
`ifdef CLUSTER_BBOX_EN
    o.r.min_x = out_min_x; o.r.min_y = out_min_y; o.r.min_z = out_min_z;
    o.r.max_x = out_max_x; o.r.max_y = out_max_y; o.r.max_z = out_max_z;
`endif
    return o;
  endfunction

  task automatic push_exp(input int cl, input int cnt, input int sx, input int sy, input int sz,
                          input int mnx, input int mxx, input int mny, input int mxy,
                          input int mnz, input int mxz);
    exp_t e;
    e = '0;
    e.cl = LABEL_W'(cl);
    e.r.count = CNT_W'(cnt);
    e.r.sum_x = SUM_W'(sx); e.r.sum_y = SUM_W'(sy); e.r.sum_z = SUM_W'(sz);
`ifdef CLUSTER_BBOX_EN
    e.r.min_x = COORD_W'(mnx); e.r.max_x = COORD_W'(mxx);
    e.r.min_y = COORD_W'(mny); e.r.max_y = COORD_W'(mxy);
    e.r.min_z = COORD_W'(mnz); e.r.max_z = COORD_W'(mxz);
`else
    if (mnx + mxx + mny + mxy + mnz + mxz < 0) e.cl = '0;
`endif
    exp_q.push_back(e);
  endtask

  // Reference model: recompute every cluster's record from the memory image.
  task automatic push_model();
    int cnt [K];
    int sum [K][3];
    int mn  [K][3];
    int mx  [K][3];
    int v   [3];
    for (int c = 0; c < K; c++) begin
      cnt[c] = 0;
      for (int a = 0; a < 3; a++) begin
        sum[c][a] = 0; mn[c][a] = (1 << COORD_W) - 1; mx[c][a] = 0;
      end
    end
    for (int p = 0; p < N_POINTS; p++) begin
      int l;
      l = int'(mem_l[p]);
      v[0] = int'(mem_x[p]); v[1] = int'(mem_y[p]); v[2] = int'(mem_z[p]);
      if (l < K) begin
        cnt[l]++;
        for (int a = 0; a < 3; a++) begin
          sum[l][a] += v[a];
          if (v[a] < mn[l][a]) mn[l][a] = v[a];
          if (v[a] > mx[l][a]) mx[l][a] = v[a];
        end
      end
    end
    for (int c = 0; c < K; c++)
      push_exp(c, cnt[c], sum[c][0], sum[c][1], sum[c][2],
               mn[c][0], mx[c][0], mn[c][1], mx[c][1], mn[c][2], mx[c][2]);
  endtask

  task automatic load_base();
    int tx [N_POINTS] = '{9, 10, 11, 12, 50, 51, 50, 51, 88, 92, 90, 91};
    int ty [N_POINTS] = '{8, 9, 10, 12, 50, 50, 50, 50, 18, 22, 20, 21};
    int tz [N_POINTS] = '{9, 10, 10, 11, 50, 51, 51, 51, 69, 72, 70, 71};
    for (int p = 0; p < N_POINTS; p++) begin
      mem_x[p] = COORD_W'(tx[p]); mem_y[p] = COORD_W'(ty[p]); mem_z[p] = COORD_W'(tz[p]);
      mem_l[p] = LABEL_W'(p / 4);
    end
  endtask

  // Pulses start and consumes records until done. ready_mode 0: ready always
  // high; 1: ready follows 1,0,0,1 over successive valid cycles. mid_start
  // re-pulses start in that cycle (negative: never). Cycle 0 is the start edge.
  task automatic run_scan(input int ready_mode, input int mid_start,
                          output int first_valid, output int done_cycle, output int hs);
    int   v;
    logic stalled;
    exp_t prev, obs, e;
    first_valid = -1; done_cycle = -1; hs = 0; v = 0; stalled = 1'b0; prev = '0;
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      start = (c == mid_start);
      if (c == 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b want 1", busy); end
      end
      if (done === 1'b1) begin done_cycle = c; break; end
      if (out_valid === 1'b1) begin
        obs = observe();
        if (first_valid < 0) first_valid = c;
        if (stalled) begin
          checks++;
          if (obs !== prev) begin
            errors++; $display("FAIL stall_hold: got %h want %h", obs, prev);
          end
        end
        out_ready = (ready_mode == 0) ? 1'b1 : ((v % 4 == 0) || (v % 4 == 3));
        v++;
        if (out_ready) begin
          hs++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL extra_record: got cluster %0d want none", out_cluster);
          end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
              errors++;
              $display("FAIL record_c%0d: got cl=%0d n=%0d s=%0d/%0d/%0d (%h) want cl=%0d n=%0d s=%0d/%0d/%0d (%h)",
                       e.cl, obs.cl, obs.r.count, obs.r.sum_x, obs.r.sum_y, obs.r.sum_z, obs,
                       e.cl, e.r.count, e.r.sum_x, e.r.sum_y, e.r.sum_z, e);
            end
          end
        end
        stalled = !out_ready;
        prev = obs;
      end
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0; out_ready = 1'b1;
    checks++;
    if (done_cycle < 0) begin
      errors++; $display("FAIL done_timeout: got no done want done within 200 cycles");
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL after_done: got done=%b busy=%b want 0 0", done, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL leftover_records: got %0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rd_addr, out_valid, busy, done, lbl_err} !== '0) begin
      errors++; $display("FAIL reset_status: got addr=%0d v=%b busy=%b done=%b err=%b want all 0",
                         rd_addr, out_valid, busy, done, lbl_err);
    end
    checks++;
    if (observe() !== '0) begin
      errors++; $display("FAIL reset_record: got %h want 0", observe());
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int fv, dc, hs;
    load_base();
    push_exp(0, 4,  42,  39,  40,  9, 12,  8, 12,  9, 11);
    push_exp(1, 4, 202, 200, 203, 50, 51, 50, 50, 50, 51);
    push_exp(2, 4, 361,  81, 282, 88, 92, 18, 22, 69, 72);
    run_scan(0, -1, fv, dc, hs);
    checks++;
    if (fv != N_POINTS + 2) begin errors++; $display("FAIL first_valid_cycle: got %0d want %0d", fv, N_POINTS + 2); end
    checks++;
    if (dc != N_POINTS + K + 2) begin errors++; $display("FAIL done_cycle: got %0d want %0d", dc, N_POINTS + K + 2); end
    checks++;
    if (hs != K) begin errors++; $display("FAIL handshakes: got %0d want %0d", hs, K); end
    checks++;
    if (lbl_err !== 1'b0) begin errors++; $display("FAIL lbl_err_clean: got %b want 0", lbl_err); end
  endtask

  task automatic test_empty_clusters();
    int fv, dc, hs;
    load_base();
    for (int p = 0; p < N_POINTS; p++) mem_l[p] = LABEL_W'(1);
    push_model();
    run_scan(0, -1, fv, dc, hs);
    checks++;
    if (hs != K) begin errors++; $display("FAIL empty_handshakes: got %0d want %0d", hs, K); end
  endtask

  task automatic test_bad_label_stall();
    int fv, dc, hs;
    load_base();
    mem_l[5] = LABEL_W'(3);
    push_model();
    run_scan(1, -1, fv, dc, hs);
    checks++;
    if (hs != K) begin errors++; $display("FAIL stall_handshakes: got %0d want %0d", hs, K); end
    checks++;
    if (lbl_err !== 1'b1) begin errors++; $display("FAIL lbl_err_set: got %b want 1", lbl_err); end
  endtask

  task automatic test_start_during_scan();
    int fv, dc, hs;
    load_base();
    push_model();
    run_scan(0, 4, fv, dc, hs);
    checks++;
    if (dc != N_POINTS + K + 2) begin errors++; $display("FAIL mid_start_done_cycle: got %0d want %0d", dc, N_POINTS + K + 2); end
    checks++;
    if (lbl_err !== 1'b0) begin errors++; $display("FAIL lbl_err_cleared: got %b want 0", lbl_err); end
  endtask

  task automatic test_reset_mid();
    int seen;
    load_base();
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if ({rd_addr, out_valid, busy, done, lbl_err} !== '0 || observe() !== '0) begin
      errors++; $display("FAIL mid_reset_values: got addr=%0d v=%b busy=%b done=%b want all 0",
                         rd_addr, out_valid, busy, done);
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL mid_reset_activity: got %0d active cycles want 0", seen); end
    test_basic();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_clusters();
    test_bad_label_stall();
    test_start_during_scan();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
